// File: rtl/genesis_pad_reader_pkg.sv
// Shared constants and helpers for the Genesis pad reader: phase map, Saidas
// bit layout, pin positions and the per-pad shadow record.
package genesis_pad_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FASE,
    PUBLICA
  } estado_t;

  localparam int NUM_FASES = 8;

  localparam logic [2:0] FASE_INICIAL  = 3'd0;
  localparam logic [2:0] FASE_A_START  = 3'd1;
  localparam logic [2:0] FASE_DPAD     = 3'd2;
  localparam logic [2:0] FASE_B_C      = 3'd4;
  localparam logic [2:0] FASE_ID6      = 3'd5;
  localparam logic [2:0] FASE_XYZ      = 3'd6;
  localparam logic [2:0] FASE_ULTIMA   = 3'd7;

  // Bit k set means phase k drives Select low.
  localparam logic [NUM_FASES-1:0] FASES_SELECT_BAIXO = 8'b1010_1010;

  localparam int BIT_MODE  = 11;
  localparam int BIT_START = 10;
  localparam int BIT_Z     = 9;
  localparam int BIT_Y     = 8;
  localparam int BIT_X     = 7;
  localparam int BIT_C     = 6;
  localparam int BIT_B     = 5;
  localparam int BIT_A     = 4;
  localparam int BIT_RIGHT = 3;
  localparam int BIT_LEFT  = 2;
  localparam int BIT_DOWN  = 1;
  localparam int BIT_UP    = 0;

  localparam int PINO1 = 0;
  localparam int PINO2 = 1;
  localparam int PINO3 = 2;
  localparam int PINO4 = 3;
  localparam int PINO6 = 4;
  localparam int PINO9 = 5;

  typedef struct packed {
    logic presente;
    logic seis;
    logic mode;
    logic start;
    logic z;
    logic y;
    logic x;
    logic c;
    logic b;
    logic a;
    logic right;
    logic left;
    logic down;
    logic up;
  } sombra_t;

  function automatic logic select_da_fase(input logic [2:0] fase);
    return !FASES_SELECT_BAIXO[fase];
  endfunction

  // Fold one phase's pin snapshot (active-low) into the shadow record.
  function automatic sombra_t amostra(input sombra_t s, input logic [2:0] fase,
                                      input logic [5:0] p);
    sombra_t r;
    r = s;
    unique case (fase)
      FASE_A_START: begin
        r.a        = !p[PINO6];
        r.start    = !p[PINO9];
        r.presente = !p[PINO3] && !p[PINO4];
      end
      FASE_DPAD: begin
        r.up    = !p[PINO1];
        r.down  = !p[PINO2];
        r.left  = !p[PINO3];
        r.right = !p[PINO4];
      end
      FASE_B_C: begin
        r.b = !p[PINO6];
        r.c = !p[PINO9];
      end
      FASE_ID6: r.seis = (p[PINO4:PINO1] == 4'b0000);
      FASE_XYZ: begin
        r.z    = !p[PINO1];
        r.y    = !p[PINO2];
        r.x    = !p[PINO3];
        r.mode = !p[PINO4];
      end
      default: r = s;
    endcase
    return r;
  endfunction

  // Absent pads publish nothing; three-button pads never report X/Y/Z/Mode.
  function automatic logic [11:0] publica(input sombra_t s);
    logic [11:0] w;
    // NOTE: start from an all-zero default so every bit has a value on every
    // path; in combinational code this is what keeps a latch from appearing.
    w = '0;
    if (s.presente) begin
      w[BIT_UP]    = s.up;
      w[BIT_DOWN]  = s.down;
      w[BIT_LEFT]  = s.left;
      w[BIT_RIGHT] = s.right;
      w[BIT_A]     = s.a;
      w[BIT_B]     = s.b;
      w[BIT_C]     = s.c;
      w[BIT_START] = s.start;
      if (s.seis) begin
        w[BIT_X]    = s.x;
        w[BIT_Y]    = s.y;
        w[BIT_Z]    = s.z;
        w[BIT_MODE] = s.mode;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/detector_borda_sinc.sv
// Two-flop synchroniser for an asynchronous input followed by a falling-edge
// detector; borda is a one-cycle pulse.
module detector_borda_sinc (
  input  logic Clock50,
  input  logic Reset,
  input  logic entrada,
  output logic borda
);

  // sinc[1:0] is the synchroniser, sinc[2] holds the previous synchronised value.
  logic [2:0] sinc;

  always_ff @(posedge Clock50) begin
    if (Reset) begin
      sinc <= '0;
    end else begin
      // NOTE: non-blocking assignment so each flop takes the value its
      // neighbour had before this edge; blocking would collapse the chain.
      sinc <= {sinc[1:0], entrada};
    end
  end

  assign borda = sinc[2] & ~sinc[1];

endmodule

// File: rtl/genesis_pad_reader.sv
// Reads up to four Sega Genesis pads sharing one Select line: eight Select
// phases per frame, sampled into shadows, published atomically with Valido.
module genesis_pad_reader
  import genesis_pad_reader_pkg::*;
#(
  parameter int NUM_PADS     = 2,
  parameter int PHASE_CYCLES = 1000
) (
  input  logic                  Clock50,
  input  logic                  Reset,
  input  logic                  v_sync,
  input  logic                  Disparo,
  input  logic [6*NUM_PADS-1:0] Pinos,
  output logic                  Select,
  output logic [12*NUM_PADS-1:0] Saidas,
  output logic [NUM_PADS-1:0]   Tipo6,
  output logic [NUM_PADS-1:0]   Conectado,
  output logic                  Valido,
  output logic                  Ocupado
);

  localparam int CW = $clog2(PHASE_CYCLES);
  localparam logic [CW-1:0] CNT_ULTIMO = CW'(PHASE_CYCLES - 1);

  estado_t       estado;
  logic [2:0]    fase;
  logic [CW-1:0] cnt;
  sombra_t       sombra [NUM_PADS];
  logic          borda_vsync;
  logic          gatilho;

  detector_borda_sinc u_detector (
    .Clock50 (Clock50),
    .Reset   (Reset),
    .entrada (v_sync),
    .borda   (borda_vsync)
  );

  // Either source starts a frame; simultaneous requests merge into one.
  assign gatilho = borda_vsync | Disparo;

  always_ff @(posedge Clock50) begin
    if (Reset) begin
      estado    <= IDLE;
      fase      <= FASE_INICIAL;
      cnt       <= '0;
      Select    <= 1'b1;
      Ocupado   <= 1'b0;
      Valido    <= 1'b0;
      Saidas    <= '0;
      Tipo6     <= '0;
      Conectado <= '0;
      // NOTE: the shadow array is a handful of flops rather than a RAM, so it
      // can be reset; doing so keeps a post-reset frame free of stale buttons.
      for (int p = 0; p < NUM_PADS; p++) sombra[p] <= '0;
    end else begin
      Valido <= 1'b0;
      unique case (estado)
        IDLE: begin
          if (gatilho) begin
            estado  <= FASE;
            fase    <= FASE_INICIAL;
            cnt     <= '0;
            Select  <= select_da_fase(FASE_INICIAL);
            Ocupado <= 1'b1;
          end
        end

        FASE: begin
          if (cnt == CNT_ULTIMO) begin
            cnt <= '0;
            for (int p = 0; p < NUM_PADS; p++)
              sombra[p] <= amostra(sombra[p], fase, Pinos[6*p +: 6]);
            if (fase == FASE_ULTIMA) begin
              // Phase 7 samples nothing, so the shadows are already final here.
              estado <= PUBLICA;
              Select <= 1'b1;
              Valido <= 1'b1;
              for (int p = 0; p < NUM_PADS; p++) begin
                Saidas[12*p +: 12] <= publica(sombra[p]);
                Tipo6[p]           <= sombra[p].presente & sombra[p].seis;
                Conectado[p]       <= sombra[p].presente;
              end
            end else begin
              fase   <= fase + 3'd1;
              Select <= select_da_fase(fase + 3'd1);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PUBLICA: begin
          estado  <= IDLE;
          Ocupado <= 1'b0;
        end

        default: begin
          estado  <= IDLE;
          Select  <= 1'b1;
          Ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule
